// File: rtl/mem_loader.sv
// Stream-to-memory loader: writes `length` bytes from a valid/ready stream starting at base_addr.
// Optional read-back check of every written byte is enabled by defining MEM_LOADER_VERIFY_EN.
module mem_loader #(
  parameter int WE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [14:0] base_addr,
  input  logic [15:0] length,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout,
  output logic        mem_en,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_STROBE,
    S_HOLD,
`ifdef MEM_LOADER_VERIFY_EN
    S_VERIFY,
`endif
    S_DONE
  } state_t;

  localparam logic [2:0] STROBE_LAST = 3'(WE_CYCLES - 1);
  localparam logic [15:0] MAX_LEN = 16'd32768;

  state_t      state_q, state_d;
  logic [14:0] base_q, base_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        last_byte;

  assign last_byte = (idx_q + 16'd1) == len_q;

`ifndef MEM_LOADER_VERIFY_EN
  logic unused_dout;
  assign unused_dout = ^mem_dout;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length == 16'd0 || length > MAX_LEN) state_d = S_DONE;
          else                                     state_d = S_WAIT;
        end
      end
      S_WAIT:   if (s_valid) state_d = S_SETUP;
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: if (cnt_q == STROBE_LAST) state_d = S_HOLD;
`ifdef MEM_LOADER_VERIFY_EN
      S_HOLD:   state_d = S_VERIFY;
      S_VERIFY: state_d = (mem_dout != din_q || last_byte) ? S_DONE : S_WAIT;
`else
      S_HOLD:   state_d = last_byte ? S_DONE : S_WAIT;
`endif
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Address and data are latched on byte acceptance so they stay frozen through SETUP/STROBE/HOLD.
  always_comb begin
    base_d = base_q;
    len_d  = len_q;
    idx_d  = idx_q;
    addr_d = addr_q;
    din_d  = din_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = length > MAX_LEN;
          if (length != 16'd0 && length <= MAX_LEN) begin
            base_d = base_addr;
            len_d  = length;
            idx_d  = 16'd0;
          end
        end
      end
      S_WAIT: begin
        if (s_valid) begin
          din_d  = s_data;
          addr_d = base_q + idx_q[14:0];
        end
      end
      S_SETUP:  cnt_d = 3'd0;
      S_STROBE: cnt_d = cnt_q + 3'd1;
`ifdef MEM_LOADER_VERIFY_EN
      S_VERIFY: begin
        idx_d = idx_q + 16'd1;
        if (mem_dout != din_q) err_d = 1'b1;
      end
`else
      S_HOLD:   idx_d = idx_q + 16'd1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      addr_q <= '0;
      din_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Strobes decode straight from the state register so reset drops them without a clock.
  always_comb begin
    s_ready  = (state_q == S_WAIT);
    mem_we   = (state_q == S_STROBE);
`ifdef MEM_LOADER_VERIFY_EN
    mem_en   = (state_q == S_STROBE) || (state_q == S_VERIFY);
`else
    mem_en   = (state_q == S_STROBE);
`endif
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    error    = err_q;
    mem_addr = addr_q;
    mem_din  = din_q;
  end

endmodule

// File: tb/tb_mem_loader.sv
// Randomized bench for mem_loader: a queue of expected (address, byte) writes derived from
// base/length/stream contents is checked against every observed write strobe.
`timescale 1ns/1ps
module tb_mem_loader;
  localparam int WE = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic [14:0] base_addr;
  logic [15:0] length;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [14:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        mem_en;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        error;

  mem_loader #(.WE_CYCLES(WE)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_en(mem_en), .mem_we(mem_we),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, combinational read with an optional stuck-at-zero location.
  logic [7:0]  mem [0:32767];
  logic        fault_on;
  logic [14:0] fault_addr;
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_din;
  assign mem_dout = (fault_on && mem_addr == fault_addr) ? 8'h00 : mem[mem_addr];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [22:0] exp_q [$];
  bit          exp_err;
  logic [7:0]  bytes_a [0:63];

  int          cyc = 0;
  int          acc_cyc = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          wlen = 0;
  logic        we_prev = 1'b0;
  logic        done_prev = 1'b0;
  logic [14:0] st_addr;
  logic [7:0]  st_din;

  always @(negedge clk) begin : monitor
    logic [22:0] w;
    cyc++;
    if (rst) begin
      we_prev   = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (mem_we) chk("we_without_en", int'(mem_en), 1);
`ifndef MEM_LOADER_VERIFY_EN
      if (mem_en) chk("en_without_we", int'(mem_we), 1);
`endif
      if (s_valid && s_ready) begin
        acc_cyc = cyc;
        acc_cnt++;
      end
      if (mem_we && !we_prev) begin
        chk("write_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk("wr_addr", int'(mem_addr), int'(w[22:8]));
          chk("wr_data", int'(mem_din), int'(w[7:0]));
        end
        chk("setup_latency", cyc - acc_cyc, 2);
        wlen    = 1;
        st_addr = mem_addr;
        st_din  = mem_din;
      end else if (mem_we) begin
        wlen++;
        chk("addr_stable", int'(mem_addr), int'(st_addr));
        chk("din_stable", int'(mem_din), int'(st_din));
      end
      if (!mem_we && we_prev) chk("strobe_len", wlen, WE);
      if (done) begin
        done_cnt++;
        chk("done_single", int'(done_prev), 0);
        chk("done_error", int'(error), int'(exp_err));
        chk("done_pending", exp_q.size(), 0);
      end
      if (done_prev) chk("busy_after_done", int'(busy), 0);
      we_prev   = mem_we;
      done_prev = done;
    end
  end

  task automatic fill_random(input int n);
    for (int k = 0; k < n && k < 64; k++) bytes_a[k] = 8'($urandom);
  endtask

  task automatic run_load(input logic [14:0] b, input int n, input bit gaps, input bit spam,
                          input int rst_at);
    int n_acc, i, t, lat, dc0, ac0, nst, a;
    bit fire, we_s;
    exp_err = 1'b0;
    n_acc   = 0;
    if (n > 32768) exp_err = 1'b1;
    else begin
      for (int k = 0; k < n; k++) begin
        a = (int'(b) + k) % 32768;
        exp_q.push_back({a[14:0], bytes_a[k]});
        n_acc++;
`ifdef MEM_LOADER_VERIFY_EN
        if (fault_on && a[14:0] == fault_addr && bytes_a[k] != 8'h00) begin
          exp_err = 1'b1;
          break;
        end
`endif
      end
    end
    dc0 = done_cnt;
    ac0 = acc_cnt;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = n[15:0];
    @(posedge clk); #1;
    start = 1'b0;
    i = 0; t = 0; nst = 0; we_s = 1'b0;
    while (i < n_acc && t < n_acc * (WE + 3) * 4 + 40) begin
      if (mem_we && !we_s) nst++;
      we_s = mem_we;
      if (rst_at != 0 && nst == rst_at && mem_we) begin
        rst = 1'b1;
        #1;
        chk("rst_mem_en", int'(mem_en), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_din", int'(mem_din), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) begin
          s_valid = 1'b1; s_data = 8'($urandom);
          @(posedge clk); #1;
        end
        s_valid = 1'b0;
        chk("rst_no_done", done_cnt - dc0, 0);
        chk("rst_idle_busy", int'(busy), 0);
        return;
      end
      s_valid = !(gaps && $urandom_range(0, 2) == 0);
      s_data  = s_valid ? bytes_a[i] : 8'($urandom);
      if (spam) begin
        start     = ($urandom_range(0, 3) == 0);
        base_addr = 15'($urandom);
        length    = 16'($urandom_range(0, 9));
      end
      fire = s_valid && s_ready;
      @(posedge clk); #1;
      if (fire) i++;
      t++;
    end
    start = 1'b0;
    chk("bytes_taken", i, n_acc);
    // Stray valid data while the loader is not in WAIT_DATA must not be consumed.
    s_valid = 1'b1;
    s_data  = 8'($urandom);
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", int'(done), 1);
    if (n_acc == 0) chk("nowork_done_latency", int'(lat <= 1), 1);
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("done_pulses", done_cnt - dc0, 1);
    chk("accepted", acc_cnt - ac0, n_acc);
    chk("error_flag", int'(error), int'(exp_err));
    chk("idle_busy", int'(busy), 0);
    for (int k = 0; k < n_acc; k++) begin
      a = (int'(b) + k) % 32768;
      chk("mem_content", int'(mem[a[14:0]]), int'(bytes_a[k]));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    s_data = '0; s_valid = 1'b0; fault_on = 1'b0; fault_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_s_ready", int'(s_ready), 0);
    chk("reset_mem_en", int'(mem_en), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_mem_addr", int'(mem_addr), 0);
    rst = 1'b0;

    bytes_a[0] = 8'hA1; bytes_a[1] = 8'hB2; bytes_a[2] = 8'hC3;
    run_load(15'h1000, 3, 1'b0, 1'b0, 0);
    chk("lit_1000", int'(mem[15'h1000]), 8'hA1);
    chk("lit_1001", int'(mem[15'h1001]), 8'hB2);
    chk("lit_1002", int'(mem[15'h1002]), 8'hC3);
    chk("lit_err0", int'(error), 0);

    bytes_a[0] = 8'h11; bytes_a[1] = 8'h22; bytes_a[2] = 8'h33; bytes_a[3] = 8'h44;
    run_load(15'h7FFE, 4, 1'b0, 1'b0, 0);
    chk("lit_7fff", int'(mem[15'h7FFF]), 8'h22);
    chk("lit_wrap0", int'(mem[15'h0000]), 8'h33);
    chk("lit_wrap1", int'(mem[15'h0001]), 8'h44);

    run_load(15'h0123, 0, 1'b0, 1'b0, 0);
    run_load(15'h0200, 32769, 1'b0, 1'b0, 0);
    chk("lit_too_long_err", int'(error), 1);

    fill_random(3);
    run_load(15'h0400, 3, 1'b0, 1'b0, 2);
    fill_random(5);
    run_load(15'h0500, 5, 1'b1, 1'b0, 0);
    chk("lit_err_cleared", int'(error), 0);

    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(1, 20);
      fill_random(n);
      run_load(15'($urandom), n, 1'b1, 1'b1, 0);
    end

`ifdef MEM_LOADER_VERIFY_EN
    fault_on = 1'b1; fault_addr = 15'h2001;
    bytes_a[0] = 8'h55; bytes_a[1] = 8'h66; bytes_a[2] = 8'h77;
    run_load(15'h2000, 3, 1'b0, 1'b0, 0);
    chk("lit_verify_err", int'(error), 1);
    chk("lit_verify_no3rd", int'(mem[15'h2002] == 8'h77), 0);
    fault_on = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
